// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 32;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Caller slices the low num_digits bits; out-of-range idx yields all zeros.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned num_digits);
    logic [MAX_DIGITS-1:0] oh;
    oh = '0;
    if (idx < num_digits && idx < MAX_DIGITS) begin
      oh[idx] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle between a value source (master) and the scan controller (slave).
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg_pkg::*;

    logic [NIBBLE_W*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]          digit_en;
    logic                           blank_lz;
    nibble_t                        bcd;
    logic [NUM_DIGITS-1:0]          an;
    logic                           frame_tick;

    modport master (
        output value, digit_en, blank_lz,
        input  bcd, an, frame_tick
    );

    modport slave (
        input  value, digit_en, blank_lz,
        output bcd, an, frame_tick
    );

endinterface

// File: rtl/refresh_divider.sv
// Free-running modulo-REFRESH_DIV counter; slot_end_o marks the last cycle of each period.
module refresh_divider #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end_o
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV + 1);
    localparam logic [DIV_W-1:0] LastDiv = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign slot_end_o = (div_q == LastDiv);

    always_comb begin
        div_d = div_q + 1'b1;
        if (slot_end_o) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with a frame-coherent
// shadow value, per-digit enable and leading-zero blanking.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic                clk,
    input logic                rst_n,
    seven_seg_scanner_if.slave bus_io
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    logic                           slot_end;
    logic                           frame_end;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic [NIBBLE_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
    nibble_t                        bcd_q;
    logic [NUM_DIGITS-1:0]          en_q, en_d;
    logic [NUM_DIGITS-1:0]          an_q;
    logic                           frame_tick_q;
    logic [NUM_DIGITS-1:0]          lz;
    logic [NUM_DIGITS-1:0]          lit;
    logic [MAX_DIGITS-1:0]          idx_oh;
    logic                           upper_zero;

    refresh_divider #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_refresh_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_end_o(slot_end)
    );

    assign frame_end = slot_end && (idx_q == LastIdx);

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            shadow_d = bus_io.value;
        end
    end

    // Walk from the top digit down; a digit is a leading zero while everything above it is zero.
    always_comb begin
        lz         = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz[i]      = bus_io.blank_lz && (i != 0) && upper_zero;
        end
    end

    assign lit    = bus_io.digit_en & ~lz;
    assign idx_oh = onehot(32'(idx_q), NUM_DIGITS);
    assign en_d   = idx_oh[NUM_DIGITS-1:0] & lit;

    // an trails bcd by one cycle to line up with the decoder's registered seg output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            shadow_q     <= '0;
            bcd_q        <= '0;
            en_q         <= '0;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            bcd_q        <= shadow_q[idx_q*NIBBLE_W +: NIBBLE_W];
            en_q         <= en_d;
            an_q         <= ~en_q;
            frame_tick_q <= frame_end;
        end
    end

    assign bus_io.bcd        = bcd_q;
    assign bus_io.an         = an_q;
    assign bus_io.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed checks of seven_seg_scanner (4 digits) at REFRESH_DIV = 4 and 1.
module tb_seven_seg_scanner;
    import seg_pkg::*;

    localparam int unsigned N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] v_value = 16'h0;
    logic [3:0]  v_en    = 4'hF;
    logic        v_blz   = 1'b0;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) if4 ();
    seven_seg_scanner_if #(.NUM_DIGITS(N)) if1 ();

    assign if4.value    = v_value;
    assign if4.digit_en = v_en;
    assign if4.blank_lz = v_blz;
    assign if1.value    = v_value;
    assign if1.digit_en = v_en;
    assign if1.blank_lz = v_blz;

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(if4)
    );

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(if1)
    );

    logic [3:0] bcd_w[2];
    logic [3:0] an_w[2];
    logic       ft_w[2];
    assign bcd_w[0] = if4.bcd;
    assign bcd_w[1] = if1.bcd;
    assign an_w[0]  = if4.an;
    assign an_w[1]  = if1.an;
    assign ft_w[0]  = if4.frame_tick;
    assign ft_w[1]  = if1.frame_tick;

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: slot position follows from the number of clocks since reset.
    int unsigned n_m[2];
    logic [15:0] sh_m[2];
    logic [3:0]  bcd_m[2];
    logic [3:0]  en_m[2];
    logic [3:0]  an_m[2];
    logic        ft_m[2];

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    initial begin
        int unsigned idx;
        int unsigned dv;
        bit          se;
        bit          lit;
        logic [15:0] sh_old;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    n_m[d]   = 0;
                    sh_m[d]  = 16'h0;
                    bcd_m[d] = 4'h0;
                    en_m[d]  = 4'h0;
                    an_m[d]  = 4'hF;
                    ft_m[d]  = 1'b0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    dv       = div_of(d);
                    idx      = (n_m[d] / dv) % N;
                    se       = (n_m[d] % dv) == dv - 1;
                    sh_old   = sh_m[d];
                    an_m[d]  = ~en_m[d];
                    bcd_m[d] = 4'((sh_old >> (4 * idx)) & 16'hF);
                    lit      = v_en[idx] && !(v_blz && idx != 0 && (sh_old >> (4 * idx)) == 16'h0);
                    en_m[d]  = lit ? 4'(1 << idx) : 4'h0;
                    ft_m[d]  = se && (idx == N - 1);
                    if (ft_m[d]) sh_m[d] = v_value;
                    n_m[d]++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus the one-lit-digit rule.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check(d == 0 ? "bcd_div4" : "bcd_div1", 32'(bcd_w[d]), 32'(bcd_m[d]));
                check(d == 0 ? "an_div4" : "an_div1", 32'(an_w[d]), 32'(an_m[d]));
                check(d == 0 ? "ft_div4" : "ft_div1", 32'(ft_w[d]), 32'(ft_m[d]));
                check(d == 0 ? "one_low_div4" : "one_low_div1",
                      32'($countones(~an_w[d]) <= 1), 32'd1);
            end
        end
    end

    task automatic wait_ft();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ft_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_tick_seen", 32'(ok), 32'd1);
    endtask

    int cnt[16];
    int bad_pair;

    // Tally an patterns over one frame and confirm the nibble shown just before each lit cycle.
    task automatic window_counts(input logic [15:0] shown);
        logic [3:0] prev_bcd;
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        bad_pair = 0;
        prev_bcd = bcd_w[0];
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                cnt[an_w[0]]++;
                for (int j = 0; j < 4; j++) begin
                    if (!an_w[0][j] && prev_bcd != 4'((shown >> (4 * j)) & 16'hF)) bad_pair++;
                end
            end
            prev_bcd = bcd_w[0];
        end
    endtask

    logic [3:0] bcd_tab1[16] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3, 4'h3,
                                 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1};
    logic [3:0] bcd_tab2[16] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h7, 4'h7, 4'h7, 4'h7,
                                 4'h8, 4'h8, 4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [3:0] an_tab[16]   = '{4'b0111, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101,
                                 4'b1101, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1011,
                                 4'b1011, 4'b0111, 4'b0111, 4'b0111};

    initial begin
        logic [3:0]  prev_an1;
        logic [15:0] rv;

        // Reset held for 5 cycles.
        repeat (5) @(negedge clk);
        check("rst_an", 32'(an_w[0]), 32'hF);
        check("rst_bcd", 32'(bcd_w[0]), 32'h0);
        check("rst_ft", 32'(ft_w[0]), 32'h0);
        rst_n = 1'b1;

        // Asynchronous reset dropped between edges mid-scan.
        repeat (7) @(negedge clk);
        check("pre_async_an_lit", 32'(an_w[0]), 32'b1101);
        #2 rst_n = 1'b0;
        #1;
        check("async_an_div4", 32'(an_w[0]), 32'hF);
        check("async_an_div1", 32'(an_w[1]), 32'hF);
        check("async_bcd", 32'(bcd_w[0]), 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Basic scan, then a mid-frame value change that must not tear.
        v_value = 16'h1234;
        v_en    = 4'hF;
        v_blz   = 1'b0;
        wait_ft();
        check("ft_bcd_old", 32'(bcd_w[0]), 32'h0);
        prev_an1 = an_w[1];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan1_bcd", 32'(bcd_w[0]), 32'(bcd_tab1[k-1]));
            check("scan1_an", 32'(an_w[0]), 32'(an_tab[k-1]));
            check("div1_rotate", 32'(an_w[1]), 32'({prev_an1[2:0], prev_an1[3]}));
            prev_an1 = an_w[1];
            if (k == 1) check("ft_one_cycle", 32'(ft_w[0]), 32'h0);
            if (k == 6) v_value = 16'h9876;
        end
        wait_ft();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan2_bcd", 32'(bcd_w[0]), 32'(bcd_tab2[k-1]));
            if (k >= 2) check("scan2_an", 32'(an_w[0]), 32'(an_tab[k-1]));
            if (k == 1) check("ft2_one_cycle", 32'(ft_w[0]), 32'h0);
        end

        // Leading-zero blanking.
        v_value = 16'h0050;
        v_blz   = 1'b1;
        wait_ft();
        window_counts(16'h0050);
        check("lz_upper_dark", 32'(cnt[4'b0111] + cnt[4'b1011]), 32'd0);
        check("lz_digit1_lit", 32'(cnt[4'b1101]), 32'd4);
        check("lz_digit0_lit", 32'(cnt[4'b1110]), 32'd4);
        check("lz_pairing", 32'(bad_pair), 32'd0);
        v_value = 16'h0000;
        wait_ft();
        window_counts(16'h0000);
        check("lz_zero_only_d0", 32'(cnt[4'b1110] + cnt[4'b1111]), 32'd16);
        check("lz_zero_d0_cnt", 32'(cnt[4'b1110]), 32'd4);

        // Per-digit enable.
        v_value = 16'hABCD;
        v_en    = 4'b0101;
        v_blz   = 1'b0;
        wait_ft();
        window_counts(16'hABCD);
        check("en_dark", 32'(cnt[4'b1101] + cnt[4'b0111]), 32'd0);
        check("en_d0_slot", 32'(cnt[4'b1110]), 32'd4);
        check("en_d2_slot", 32'(cnt[4'b1011]), 32'd4);
        check("en_pairing", 32'(bad_pair), 32'd0);

        // Randomised traffic, leading-zero heavy.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                rv = 16'h0;
                for (int j = 0; j < 4; j++) begin
                    if ($urandom_range(1) == 1) rv = rv | (16'($urandom_range(15)) << (4 * j));
                end
                v_value = rv;
                v_en    = 4'($urandom_range(15));
                v_blz   = 1'($urandom_range(1));
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexing scan controller for an NUM_DIGITS-digit common-anode 7-segment display. It sits directly upstream of the BCD-to-7-segment decoder. Each refresh slot it presents one digit's nibble on bcd to the decoder and drives the matching active-low anode line. The anode output is delayed one clock so that it changes on the same edge as the decoder's registered seg output. A frame-coherent shadow copy of the input value prevents tearing, and the block supports per-digit enable and leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of display digits; digit 0 is least significant.
REFRESH_DIV, 100000, clock cycles per digit slot; legal range is 1 or greater (100 MHz clock gives 1 kHz per digit).
DIV_W, $clog2(REFRESH_DIV+1), width of the slot divider counter; derived, never overridden.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
value  input  4*NUM_DIGITS  packed nibbles; digit i = value[4i+3:4i]
digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit always dark
blank_lz  input  1  1 = suppress leading zeros
bcd  output  4  nibble to the decoder's bcd input
an  output  NUM_DIGITS  anode drive, active-low; an[i] low = digit i lit
frame_tick  output  1  one-cycle pulse when a new frame's shadow value takes effect

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-scan. While reset is held:
  - div = 0, idx = 0, shadow = 0, bcd = 4'h0.
  - en_q = 0, an = all ones (display dark), frame_tick = 0.
- Divider: div counts 0..REFRESH_DIV-1 and wraps to 0. slot_end = (div == REFRESH_DIV-1).
- Digit index: on slot_end, idx increments, wrapping from NUM_DIGITS-1 to 0. Scan order is 0, 1, ..., NUM_DIGITS-1, then repeat.
- Shadow capture:
  - On slot_end with idx == NUM_DIGITS-1 (frame boundary), shadow <= value.
  - frame_tick is 1 in the cycle after that edge, and 0 otherwise.
  - Changes to value mid-frame are invisible until the next boundary.
  - The first post-reset frame displays shadow = 0.
- Pipeline, per clock:
  - Stage 1: bcd <= shadow nibble[idx]; en_q <= onehot(idx) AND lit(idx).
  - Stage 2: an <= ~en_q.
  - Result: an lags bcd by exactly one cycle, matching the decoder's one-cycle seg register, so seg and an switch on the same edge (no ghosting).
- lit(i) rules:
  - lit(i) = digit_en[i] AND NOT lz(i).
  - lz(i) = blank_lz AND (i != 0) AND (nibbles i..NUM_DIGITS-1 of shadow are all zero).
  - Digit 0 is never leading-zero blanked.
- A blanked digit still gets its slot time (constant duty cycle): bcd carries its nibble and all an bits are high.
- Nibbles 0xA–0xF pass through unchanged; the decoder renders them as hex.
- digit_en and blank_lz are sampled every cycle, not shadowed; a change takes effect within 2 cycles.
- REFRESH_DIV = 1: slot_end every cycle, idx advances every clock, an still lags bcd by 1.
- At most one an bit is low in any cycle.

Decomposition:
- Package seg_pkg:
  - NIBBLE_W = 4.
  - Typedef nibble_t (logic [3:0]).
  - Function onehot(idx, NUM_DIGITS).
- Sub-module: refresh_divider (parameter REFRESH_DIV; outputs slot_end), reusable for other periodic ticks.
- Leading-zero logic stays inline.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset: hold rst_n=0 for 5 cycles -> an=4'b1111, bcd=0, frame_tick=0. Drop rst_n mid-scan asynchronously (between edges) -> an=4'b1111 immediately, without waiting for a clock edge.
2. Scan: value=16'h1234, digit_en=4'hF, blank_lz=0 -> after first frame_tick, bcd holds 4,3,2,1 for 4 cycles each; an is 1110,1101,1011,0111, each starting exactly 1 cycle after its bcd change.
3. No tearing: change value 16'h1234 -> 16'h9876 during the slot of digit 1 -> remaining slots of that frame still show 2,1; next frame shows 6,7,8,9, with a frame_tick pulse of exactly 1 cycle at the boundary.
4. Leading-zero blanking: value=16'h0050, blank_lz=1 -> an[3] and an[2] never low; digit 1 lit with bcd=5; digit 0 lit with bcd=0. value=16'h0000 -> only an[0] ever low.
5. Digit enable: digit_en=4'b0101, value=16'hABCD -> an[1] and an[3] stay 1; digit 0 shows bcd=D and digit 2 shows bcd=B; slot timing is unchanged at 4 cycles per digit.
6. REFRESH_DIV=1 build: an cycles 1110, 1101, 1011, 0111 every clock; checker asserts at most one an bit is low in every cycle across all tests.
